// File: rtl/instruction_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// The master side is fetch plus decode; the slave side is the queue itself.
interface instruction_queue_if #(
  parameter int AW = 2
);
  logic        push_valid;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        flush;
  logic        decode_freeze;
  logic        full;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [AW:0] count;

  modport master (
    output push_valid, push_pc, push_instr, flush, decode_freeze,
    input  full, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  push_valid, push_pc, push_instr, flush, decode_freeze,
    output full, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/instruction_queue.sv
// Fetch-to-decode prefetch buffer: a circular buffer of {pc, instr} pairs.
// A taken branch (flush) empties it.
// Full is the fetch freeze; the head is presented combinationally from registered state.
module instruction_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  instruction_queue_if.slave  q
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [63:0]   head;
  logic          full_i;
  logic          valid_i;
  logic          push_accept;
  logic          pop;

  // Full is taken from the registered count.
  // A push into a full queue is refused even when a pop frees a slot on the same edge.
  assign full_i      = (cnt == FULL_CNT);
  assign valid_i     = (cnt != '0);
  assign push_accept = q.push_valid & ~full_i & ~q.flush;
  assign pop         = valid_i & ~q.decode_freeze & ~q.flush;
  assign head        = mem[rd_ptr];

  assign q.full      = full_i;
  assign q.out_valid = valid_i;
  assign q.count     = cnt;
  assign q.out_pc    = valid_i ? head[63:32] : 32'b0;
  assign q.out_instr = valid_i ? head[31:0]  : 32'b0;

  // Pointer and occupancy control; flush overrides any push or pop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)         rd_ptr <= rd_ptr + AW'(1);
      case ({push_accept, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage is data only, so it is never reset; stale contents are masked by count
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= {q.push_pc, q.push_instr};
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue.
// A scoreboard queue holds the entries the bench expects the DUT to hold.
// Every pop is compared against the scoreboard, and table rows carry hand-derived expectations.
module tb_instruction_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic rst;

  instruction_queue_if #(.AW(AW)) qif();

  instruction_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fl;
    logic        fz;
    int          exp_count;
    logic        exp_valid;
    logic        exp_full;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare the DUT's visible state with the scoreboard
  task automatic check_state(input string tag);
    logic [63:0] exp_head;
    exp_head = (sb.size() != 0) ? sb[0] : 64'd0;
    check({tag, ".count"}, 64'(qif.count), 64'(sb.size()));
    check({tag, ".full"}, 64'(qif.full), 64'(sb.size() == DEPTH));
    check({tag, ".out_valid"}, 64'(qif.out_valid), 64'(sb.size() != 0));
    check({tag, ".head"}, {qif.out_pc, qif.out_instr}, exp_head);
  endtask

  // One clock cycle: drive inputs, check state, model the edge, then advance
  task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic fl, input logic fz, input string tag);
    logic acc;
    logic pp;
    logic [63:0] exp;
    qif.push_valid    = pv;
    qif.push_pc       = pc;
    qif.push_instr    = instr;
    qif.flush         = fl;
    qif.decode_freeze = fz;
    check_state(tag);
    acc = pv && (sb.size() != DEPTH) && !fl;
    pp  = (sb.size() != 0) && !fz && !fl;
    if (pp) begin
      exp = sb.pop_front();
      check({tag, ".pop_data"}, {qif.out_pc, qif.out_instr}, exp);
    end
    if (fl) sb.delete();
    else if (acc) sb.push_back({pc, instr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic fz);
    step(1'b0, 32'd0, 32'd0, 1'b0, fz, "idle");
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'd4,  32'hA0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 32'd4};
    vecs[1] = '{1'b1, 32'd8,  32'hA1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 32'd4};
    vecs[2] = '{1'b1, 32'd12, 32'hA2, 1'b0, 1'b1, 3, 1'b1, 1'b0, 32'd4};
    vecs[3] = '{1'b1, 32'd16, 32'hA3, 1'b0, 1'b1, 4, 1'b1, 1'b1, 32'd4};
    vecs[4] = '{1'b1, 32'd20, 32'hA4, 1'b0, 1'b1, 4, 1'b1, 1'b1, 32'd4};
    vecs[5] = '{1'b0, 32'd0,  32'h0,  1'b0, 1'b0, 3, 1'b1, 1'b0, 32'd8};
    vecs[6] = '{1'b0, 32'd0,  32'h0,  1'b0, 1'b0, 2, 1'b1, 1'b0, 32'd12};
    vecs[7] = '{1'b0, 32'd0,  32'h0,  1'b0, 1'b0, 1, 1'b1, 1'b0, 32'd16};
    vecs[8] = '{1'b0, 32'd0,  32'h0,  1'b0, 1'b0, 0, 1'b0, 1'b0, 32'd0};
    vecs[9] = '{1'b0, 32'd0,  32'h0,  1'b0, 1'b0, 0, 1'b0, 1'b0, 32'd0};

    rst = 1'b0;
    qif.push_valid = 1'b0; qif.push_pc = '0; qif.push_instr = '0;
    qif.flush = 1'b0; qif.decode_freeze = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b1;
    idle(1'b0);
    check_state("reset_idle");

    // Fill and drain order, including refused 5th push and empty-no-underflow
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].pv, vecs[i].pc, vecs[i].instr, vecs[i].fl, vecs[i].fz, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.count", i), 64'(qif.count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d.valid", i), 64'(qif.out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d.full", i), 64'(qif.full), 64'(vecs[i].exp_full));
      check($sformatf("vec%0d.pc", i), 64'(qif.out_pc), 64'(vecs[i].exp_pc));
    end

    // Wrap-around: continuous push and pop, count holds at 1
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 32'(4 * k), 32'(32'hB00 + k), 1'b0, 1'b0, "wrap");
      check("wrap.count", 64'(qif.count), 64'd1);
      check("wrap.pc", 64'(qif.out_pc), 64'(4 * k));
    end
    idle(1'b0);
    check("wrap.drained", 64'(qif.count), 64'd0);

    // Flush priority over a simultaneous push
    step(1'b1, 32'd200, 32'hC0, 1'b0, 1'b1, "fl_fill");
    step(1'b1, 32'd204, 32'hC1, 1'b0, 1'b1, "fl_fill");
    step(1'b1, 32'd208, 32'hC2, 1'b0, 1'b1, "fl_fill");
    check("flush.pre_count", 64'(qif.count), 64'd3);
    step(1'b1, 32'd100, 32'hCC, 1'b1, 1'b0, "flush");
    check("flush.count", 64'(qif.count), 64'd0);
    check("flush.valid", 64'(qif.out_valid), 64'd0);
    idle(1'b0);
    check("flush.no_pc100", 64'(qif.out_pc == 32'd100), 64'd0);
    check("flush.still_empty", 64'(qif.count), 64'd0);

    // Simultaneous push/pop at count 2
    step(1'b1, 32'd300, 32'hD0, 1'b0, 1'b1, "pp_fill");
    step(1'b1, 32'd304, 32'hD1, 1'b0, 1'b1, "pp_fill");
    step(1'b1, 32'd308, 32'hD2, 1'b0, 1'b0, "pushpop");
    check("pushpop.count", 64'(qif.count), 64'd2);
    check("pushpop.pc", 64'(qif.out_pc), 64'd304);
    step(1'b1, 32'd312, 32'hD3, 1'b0, 1'b1, "pp_fill");
    step(1'b1, 32'd316, 32'hD4, 1'b0, 1'b1, "pp_fill");
    check("full.reached", 64'(qif.full), 64'd1);

    // Full with pop and push offered: push refused, count drops, full clears
    step(1'b1, 32'd320, 32'hD5, 1'b0, 1'b0, "full_pop");
    check("full_pop.count", 64'(qif.count), 64'd3);
    check("full_pop.full", 64'(qif.full), 64'd0);
    check("full_pop.pc", 64'(qif.out_pc), 64'd308);
    step(1'b1, 32'd324, 32'hD6, 1'b0, 1'b1, "refill");
    check("refill.full", 64'(qif.full), 64'd1);

    // Flush while full, then flush while empty
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, "flush_full");
    check("flush_full.full", 64'(qif.full), 64'd0);
    check("flush_full.count", 64'(qif.count), 64'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "flush_empty");
    check("flush_empty.count", 64'(qif.count), 64'd0);

    // Asynchronous reset mid-stream
    step(1'b1, 32'd400, 32'hE0, 1'b0, 1'b1, "ar_fill");
    step(1'b1, 32'd404, 32'hE1, 1'b0, 1'b1, "ar_fill");
    step(1'b1, 32'd408, 32'hE2, 1'b0, 1'b1, "ar_fill");
    check("areset.pre_count", 64'(qif.count), 64'd3);
    qif.push_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("areset.count", 64'(qif.count), 64'd0);
    check("areset.valid", 64'(qif.out_valid), 64'd0);
    check("areset.pc", 64'(qif.out_pc), 64'd0);
    check("areset.instr", 64'(qif.out_instr), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 32'd500, 32'hF0, 1'b0, 1'b1, "post_reset");
    check("post_reset.count", 64'(qif.count), 64'd1);
    check("post_reset.pc", 64'(qif.out_pc), 64'd500);
    idle(1'b0);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
